// File: rtl/pulse_train_if.sv
// Start handshake, pulse description and status outputs for the pulse train
// generator. The master side requests trains; the slave side produces them.
interface pulse_train_if #(
  parameter int W_LEN = 8,
  parameter int W_CNT = 8
) ();
  logic             start_valid;
  logic             start_ready;
  logic [W_LEN-1:0] high_len;
  logic [W_LEN-1:0] low_len;
  logic [W_CNT-1:0] pulse_cnt;
  logic             out;
  logic             busy;
  logic             done;

  modport master (
    output start_valid, high_len, low_len, pulse_cnt,
    input  start_ready, out, busy, done
  );

  modport slave (
    input  start_valid, high_len, low_len, pulse_cnt,
    output start_ready, out, busy, done
  );
endinterface

// File: rtl/pulse_train_generator.sv
// Generates pulse_cnt pulses of high_len cycles separated by low_len low
// cycles after a valid/ready start handshake; out, busy and done are registered.
module pulse_train_generator #(
  parameter int W_LEN = 8,
  parameter int W_CNT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pulse_train_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  state_t           state, state_d;
  logic [W_LEN-1:0] high_cnt, high_cnt_d, low_cnt, low_cnt_d;
  logic [W_LEN-1:0] high_rld, high_rld_d, low_rld, low_rld_d;
  logic [W_CNT-1:0] rem_cnt, rem_cnt_d;
  logic             out_q, out_d, busy_q, busy_d, done_q, done_d;
  logic             fire;
  logic [W_LEN-1:0] high_m1, low_m1;

  assign fire = bus.start_valid && (state == IDLE);

  // Counters hold length-1 so that zero lengths collapse onto a length of one
  // and the all-ones maximum still yields the full 2^W-1 cycles.
  assign high_m1 = (bus.high_len == '0) ? '0 : bus.high_len - W_LEN'(1);
  assign low_m1  = (bus.low_len  == '0) ? '0 : bus.low_len  - W_LEN'(1);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of statements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      high_cnt <= '0;
      low_cnt  <= '0;
      high_rld <= '0;
      low_rld  <= '0;
      rem_cnt  <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      high_cnt <= high_cnt_d;
      low_cnt  <= low_cnt_d;
      high_rld <= high_rld_d;
      low_rld  <= low_rld_d;
      rem_cnt  <= rem_cnt_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every signal assigned here gets a hold default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state;
    high_cnt_d = high_cnt;
    low_cnt_d  = low_cnt;
    high_rld_d = high_rld;
    low_rld_d  = low_rld;
    rem_cnt_d  = rem_cnt;
    case (state)
      IDLE: begin
        if (fire) begin
          high_rld_d = high_m1;
          low_rld_d  = low_m1;
          if (bus.pulse_cnt != '0) begin
            state_d    = HIGH;
            high_cnt_d = high_m1;
            rem_cnt_d  = bus.pulse_cnt - W_CNT'(1);
          end
        end
      end
      HIGH: begin
        if (high_cnt == '0) begin
          if (rem_cnt == '0) begin
            state_d = IDLE;
          end else begin
            state_d   = LOW;
            low_cnt_d = low_rld;
          end
        end else begin
          high_cnt_d = high_cnt - W_LEN'(1);
        end
      end
      LOW: begin
        if (low_cnt == '0) begin
          state_d    = HIGH;
          high_cnt_d = high_rld;
          rem_cnt_d  = rem_cnt - W_CNT'(1);
        end else begin
          low_cnt_d = low_cnt - W_LEN'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, so they line up
  // with the state they describe and never glitch.
  always_comb begin
    out_d  = (state_d == HIGH);
    busy_d = (state_d != IDLE);
    done_d = ((state == HIGH) && (state_d == IDLE)) ||
             (fire && (bus.pulse_cnt == '0));
  end

  assign bus.start_ready = (state == IDLE);
  assign bus.out         = out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule
